controlador_rodadas: RTL and testbench
======================================

// Module: controlador_rodadas
// PURPOSE
//  Sequences a multi-round scoring session around the grade evaluator (nota = 10 - |ideal - sensor|).
//  Each round: fetch the target from a synchronous ideal-value ROM, wait for a valid sensor sample
//  or a timeout, drive the grader, then register and accumulate its 4-bit grade.
//  Sits between the top-level game control (iniciar/abortar) and the grader/ROM pair.
// PARAMETERS
//  N_RODADAS  4     rounds per session, 1..15
//  TIMEOUT    1000  ESPERA cycles before a round scores 0, >=1
//  SOMA_W     8     accumulator width; saturates at 2^SOMA_W-1
// PORTS
//  clock          in   1       system clock, rising edge
//  resetn         in   1       asynchronous, active-low reset
//  iniciar        in   1       start pulse; honoured only in OCIOSO or FIM
//  abortar        in   1       cancel session; highest priority after reset
//  sensor_valido  in   1       sensor sample valid, 1-cycle pulse
//  sensor         in   4       sensor reading
//  ideal_dado     in   4       ROM read data, valid 1 cycle after address
//  nota           in   4       grader result, combinational from ideal_out/sensor_out
//  endereco_ideal out  4       ROM address = current round index
//  ideal_out      out  4       registered ideal for the grader
//  sensor_out     out  4       registered sensor for the grader
//  enable_nota    out  1       grader enable, high in AVALIA only
//  rodada         out  4       current round index 0..N_RODADAS-1
//  nota_rodada    out  4       grade of the last completed round
//  nota_valida    out  1       1-cycle pulse when nota_rodada updates
//  soma           out  SOMA_W  accumulated session score
//  ocupado        out  1       high in every state except OCIOSO and FIM
//  pronto         out  1       high in FIM only
// BEHAVIOUR
//  Reset (resetn=0, async): state OCIOSO; every output and internal register 0.
//  States: OCIOSO, CARREGA, LE, ESPERA, AVALIA, PROXIMA, FIM.
//   OCIOSO: iniciar -> CARREGA; rodada<=0, soma<=0, nota_rodada<=0.
//   CARREGA: 1 cycle; covers ROM read latency -> LE.
//   LE: ideal_reg<=ideal_dado; timeout counter<=0 -> ESPERA.
//   ESPERA: counter+1 each cycle.
//    sensor_valido=1 -> sensor_reg<=sensor, tmo<=0 -> AVALIA.
//    Else if counter==TIMEOUT-1 -> tmo<=1 -> AVALIA.
//    sensor_valido wins when both occur in the same cycle.
//   AVALIA: enable_nota=1; at the edge g = tmo ? 0 : (nota>10 ? 0 : nota).
//    nota_rodada<=g; soma<=min(soma+g, 2^SOMA_W-1) -> PROXIMA.
//   PROXIMA: nota_valida=1.
//    If rodada==N_RODADAS-1 -> FIM.
//    Else rodada<=rodada+1 -> CARREGA.
//   FIM: pronto=1; soma and nota_rodada held.
//    iniciar -> CARREGA with rodada, soma and nota_rodada cleared.
//  abortar=1 in any state other than OCIOSO -> OCIOSO at the next edge.
//   pronto=0, ocupado=0; soma, rodada and nota_rodada hold their last values.
//  iniciar in CARREGA..PROXIMA is ignored.
//  Latency: sensor_valido sampled at edge t -> nota_valida high in the cycle after edge t+1.
//  Round period with an immediate sensor: 5 cycles (CARREGA, LE, ESPERA, AVALIA, PROXIMA).
//  ideal_out, sensor_out: registered; stable from LE/ESPERA through AVALIA.
//  endereco_ideal: equal to rodada at all times.
// TESTING
//  T1 N=4, ROM {5,3,9,0}, sensors {5,4,6,10}.
//     -> nota_rodada 10,9,7,0, four nota_valida pulses, soma=26, pronto=1.
//  T2 Round 1 receives no sensor_valido.
//     -> AVALIA entered exactly TIMEOUT cycles after ESPERA entry; nota_rodada=0; round 2 starts.
//  T3 sensor_valido in the same cycle the counter hits TIMEOUT-1, ideal=7, sensor=7.
//     -> nota_rodada=10.
//  T4 abortar during ESPERA of round 2.
//     -> OCIOSO next cycle, ocupado=0, pronto=0; a new iniciar gives soma=0, rodada=0.
//  T5 iniciar pulsed in ESPERA -> ignored.
//     iniciar in FIM -> CARREGA, soma cleared.
//     SOMA_W=4 with four 10s -> soma saturates at 15.
//  T6 resetn low mid-AVALIA -> outputs 0 immediately, before the next edge; state OCIOSO.

Source files
------------

// File: rtl/controlador_rodadas_if.sv
// Round controller bus: game control, ROM and grader side.
// Slave is the controller, master is whoever drives it.
interface controlador_rodadas_if #(
  parameter int SOMA_W = 8
);
  logic              iniciar;
  logic              abortar;
  logic              sensor_valido;
  logic [3:0]        sensor;
  logic [3:0]        ideal_dado;
  logic [3:0]        nota;
  logic [3:0]        endereco_ideal;
  logic [3:0]        ideal_out;
  logic [3:0]        sensor_out;
  logic              enable_nota;
  logic [3:0]        rodada;
  logic [3:0]        nota_rodada;
  logic              nota_valida;
  logic [SOMA_W-1:0] soma;
  logic              ocupado;
  logic              pronto;

  modport slave (
    input  iniciar, abortar, sensor_valido,
    input  sensor, ideal_dado, nota,
    output endereco_ideal, ideal_out, sensor_out,
    output enable_nota, rodada, nota_rodada,
    output nota_valida, soma, ocupado, pronto
  );

  modport master (
    output iniciar, abortar, sensor_valido,
    output sensor, ideal_dado, nota,
    input  endereco_ideal, ideal_out, sensor_out,
    input  enable_nota, rodada, nota_rodada,
    input  nota_valida, soma, ocupado, pronto
  );
endinterface

// File: rtl/controlador_rodadas.sv
// Multi-round scoring session sequencer.
// Fetches ideal, waits for sensor or timeout, grades, accumulates.
module controlador_rodadas #(
  parameter int N_RODADAS = 4,
  parameter int TIMEOUT   = 1000,
  parameter int SOMA_W    = 8
) (
  input  logic clock,
  input  logic resetn,
  controlador_rodadas_if.slave bus
);
  typedef enum logic [2:0] {
    OCIOSO, CARREGA, LE, ESPERA,
    AVALIA, PROXIMA, FIM
  } state_t;

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT - 1);
  localparam logic [3:0] ULTIMA =
    4'(N_RODADAS - 1);
  localparam logic [SOMA_W:0] SOMA_MAX =
    {1'b0, {SOMA_W{1'b1}}};

  state_t            r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_tmo;
  logic [3:0]        r_ideal;
  logic [3:0]        r_sensor;
  logic [3:0]        r_rodada;
  logic [3:0]        r_nota;
  logic [SOMA_W-1:0] r_soma;
  logic              r_enable;
  logic              r_valida;
  logic              r_ocupado;
  logic              r_pronto;

  state_t            w_next;
  logic              w_abort;
  logic [3:0]        w_g;
  logic [SOMA_W:0]   w_soma_ext;
  logic [SOMA_W-1:0] w_soma_sat;

  assign w_abort = bus.abortar
                && (r_state != OCIOSO);

  // Round grade: timeout or out-of-range grader result scores zero
  always_comb begin
    w_g = bus.nota;
    if (r_tmo || (bus.nota > 4'd10))
      w_g = 4'd0;
  end

  // Saturating accumulation of the round grade
  always_comb begin
    w_soma_ext = {1'b0, r_soma}
               + (SOMA_W+1)'(w_g);
    w_soma_sat = w_soma_ext[SOMA_W-1:0];
    if (w_soma_ext > SOMA_MAX)
      w_soma_sat = '1;
  end

  // Next state; abort beats everything but reset
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = OCIOSO;
    end else begin
      unique case (r_state)
        OCIOSO, FIM:
          if (bus.iniciar) w_next = CARREGA;
        CARREGA: w_next = LE;
        LE:      w_next = ESPERA;
        ESPERA:
          if (bus.sensor_valido
              || (r_cnt == CNT_MAX))
            w_next = AVALIA;
        AVALIA:  w_next = PROXIMA;
        PROXIMA:
          w_next = (r_rodada == ULTIMA)
                 ? FIM : CARREGA;
        default: w_next = OCIOSO;
      endcase
    end
  end

  // State, registered outputs and round datapath
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state   <= OCIOSO;
      r_cnt     <= '0;
      r_tmo     <= 1'b0;
      r_ideal   <= '0;
      r_sensor  <= '0;
      r_rodada  <= '0;
      r_nota    <= '0;
      r_soma    <= '0;
      r_enable  <= 1'b0;
      r_valida  <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_enable  <= (w_next == AVALIA);
      r_valida  <= (w_next == PROXIMA);
      r_pronto  <= (w_next == FIM);
      r_ocupado <= (w_next != OCIOSO)
                && (w_next != FIM);
      if (!w_abort) begin
        unique case (r_state)
          OCIOSO, FIM:
            if (bus.iniciar) begin
              r_rodada <= '0;
              r_soma   <= '0;
              r_nota   <= '0;
            end
          LE: begin
            r_ideal <= bus.ideal_dado;
            r_cnt   <= '0;
          end
          ESPERA: begin
            r_cnt <= r_cnt + CW'(1);
            if (bus.sensor_valido) begin
              r_sensor <= bus.sensor;
              r_tmo    <= 1'b0;
            end else if (r_cnt == CNT_MAX) begin
              r_tmo <= 1'b1;
            end
          end
          AVALIA: begin
            r_nota <= w_g;
            r_soma <= w_soma_sat;
          end
          PROXIMA:
            if (r_rodada != ULTIMA)
              r_rodada <= r_rodada + 4'd1;
          default: ;
        endcase
      end
    end
  end

  assign bus.endereco_ideal = r_rodada;
  assign bus.ideal_out      = r_ideal;
  assign bus.sensor_out     = r_sensor;
  assign bus.enable_nota    = r_enable;
  assign bus.rodada         = r_rodada;
  assign bus.nota_rodada    = r_nota;
  assign bus.nota_valida    = r_valida;
  assign bus.soma           = r_soma;
  assign bus.ocupado        = r_ocupado;
  assign bus.pronto         = r_pronto;
endmodule

// File: tb/tb_controlador_rodadas.sv
// Bench for controlador_rodadas: two instances (wide and
// 4-bit accumulator) share stimulus, ROM image and grader.
module tb_controlador_rodadas;
  localparam int N   = 4;
  localparam int TMO = 20;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       iniciar = 1'b0;
  logic       abortar = 1'b0;
  logic       sv = 1'b0;
  logic [3:0] sensor = '0;
  logic [3:0] rom [16];

  int ncmp = 0;
  int nerr = 0;
  int m_sum = 0;
  int m_last = 0;

  always #5 clock = ~clock;

  controlador_rodadas_if #(.SOMA_W(8)) ifa();
  controlador_rodadas_if #(.SOMA_W(4)) ifb();

  function automatic logic [3:0] grader(
    input logic [3:0] a, input logic [3:0] b);
    int ia, ib, v;
    ia = int'(a);
    ib = int'(b);
    v = 10 - ((ia > ib) ? ia - ib : ib - ia);
    return 4'(v);
  endfunction

  assign ifa.iniciar       = iniciar;
  assign ifa.abortar       = abortar;
  assign ifa.sensor_valido = sv;
  assign ifa.sensor        = sensor;
  assign ifa.nota = grader(ifa.ideal_out, ifa.sensor_out);
  assign ifb.iniciar       = iniciar;
  assign ifb.abortar       = abortar;
  assign ifb.sensor_valido = sv;
  assign ifb.sensor        = sensor;
  assign ifb.nota = grader(ifb.ideal_out, ifb.sensor_out);

  always @(posedge clock) begin
    ifa.ideal_dado <= rom[ifa.endereco_ideal];
    ifb.ideal_dado <= rom[ifb.endereco_ideal];
  end

  controlador_rodadas #(
    .N_RODADAS(N), .TIMEOUT(TMO), .SOMA_W(8)
  ) u_dut_a (
    .clock(clock), .resetn(resetn), .bus(ifa.slave)
  );

  controlador_rodadas #(
    .N_RODADAS(N), .TIMEOUT(TMO), .SOMA_W(4)
  ) u_dut_b (
    .clock(clock), .resetn(resetn), .bus(ifb.slave)
  );

  function automatic int ref_grade(input int i, input int s);
    int d;
    d = (i > s) ? i - s : s - i;
    return (d > 10) ? 0 : 10 - d;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_ocup_a"}, 32'(ifa.ocupado), 0);
    chk({tag, "_pronto_a"}, 32'(ifa.pronto), 0);
    chk({tag, "_en_a"}, 32'(ifa.enable_nota), 0);
    chk({tag, "_val_a"}, 32'(ifa.nota_valida), 0);
    chk({tag, "_soma_a"}, 32'(ifa.soma), 0);
    chk({tag, "_soma_b"}, 32'(ifb.soma), 0);
    chk({tag, "_rod_a"}, 32'(ifa.rodada), 0);
    chk({tag, "_end_a"}, 32'(ifa.endereco_ideal), 0);
    chk({tag, "_nota_a"}, 32'(ifa.nota_rodada), 0);
    chk({tag, "_ideal_a"}, 32'(ifa.ideal_out), 0);
    chk({tag, "_sens_a"}, 32'(ifa.sensor_out), 0);
    chk({tag, "_ocup_b"}, 32'(ifb.ocupado), 0);
  endtask

  // Pulse iniciar from OCIOSO/FIM; returns in CARREGA.
  task automatic start_session();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    m_sum = 0;
    chk("st_ocup", 32'(ifa.ocupado), 1);
    chk("st_pronto", 32'(ifa.pronto), 0);
    chk("st_rod", 32'(ifa.rodada), 0);
    chk("st_soma_a", 32'(ifa.soma), 0);
    chk("st_soma_b", 32'(ifb.soma), 0);
    chk("st_nota", 32'(ifa.nota_rodada), 0);
  endtask

  // Entered at a negedge inside CARREGA of round r.
  task automatic play_round(input int r, input bit give,
                            input int d, input logic [3:0] s,
                            input bit poke, input bit rst_av);
    int waited;
    int g;
    waited = 0;
    chk("rod", 32'(ifa.rodada), 32'(r));
    chk("end", 32'(ifa.endereco_ideal), 32'(r));
    @(negedge clock);
    @(negedge clock);
    chk("esp_en", 32'(ifa.enable_nota), 0);
    if (poke) begin
      iniciar = 1'b1;
      @(negedge clock);
      iniciar = 1'b0;
      waited = 1;
      chk("poke_rod", 32'(ifa.rodada), 32'(r));
      chk("poke_ocup", 32'(ifa.ocupado), 1);
    end
    if (give) begin
      repeat (d - waited) @(negedge clock);
      chk("pre_en", 32'(ifa.enable_nota), 0);
      sv = 1'b1;
      sensor = s;
      @(negedge clock);
      sv = 1'b0;
      sensor = 4'($urandom_range(0, 15));
    end else begin
      repeat (TMO - 1 - waited) @(negedge clock);
      chk("tmo_early", 32'(ifa.enable_nota), 0);
      @(negedge clock);
    end
    chk("aval_en_a", 32'(ifa.enable_nota), 1);
    chk("aval_en_b", 32'(ifb.enable_nota), 1);
    chk("ideal_out", 32'(ifa.ideal_out), 32'(rom[r]));
    if (give)
      chk("sensor_out", 32'(ifa.sensor_out), 32'(s));
    if (rst_av) begin
      #2 resetn = 1'b0;
      #1 chk_idle_zero("rst_av");
      @(negedge clock);
      resetn = 1'b1;
      return;
    end
    g = give ? ref_grade(int'(rom[r]), int'(s)) : 0;
    m_sum += g;
    m_last = g;
    @(negedge clock);
    chk("valida_a", 32'(ifa.nota_valida), 1);
    chk("valida_b", 32'(ifb.nota_valida), 1);
    chk("prox_en", 32'(ifa.enable_nota), 0);
    chk("nota_a", 32'(ifa.nota_rodada), 32'(g));
    chk("nota_b", 32'(ifb.nota_rodada), 32'(g));
    chk("soma_a", 32'(ifa.soma), 32'(sat(m_sum, 255)));
    chk("soma_b", 32'(ifb.soma), 32'(sat(m_sum, 15)));
    @(negedge clock);
    chk("valida_off", 32'(ifa.nota_valida), 0);
    if (r == N - 1) begin
      chk("fim_pronto_a", 32'(ifa.pronto), 1);
      chk("fim_pronto_b", 32'(ifb.pronto), 1);
      chk("fim_ocup", 32'(ifa.ocupado), 0);
    end else begin
      chk("next_ocup", 32'(ifa.ocupado), 1);
      chk("next_pronto", 32'(ifa.pronto), 0);
    end
  endtask

  task automatic random_session();
    bit give, poke;
    int d;
    for (int k = 0; k < N; k++)
      rom[k] = 4'($urandom_range(0, 15));
    start_session();
    for (int r = 0; r < N; r++) begin
      give = ($urandom_range(0, 3) != 0);
      poke = ($urandom_range(0, 3) == 0);
      d = $urandom_range(poke ? 1 : 0, TMO - 1);
      play_round(r, give, d,
                 4'($urandom_range(0, 15)), poke, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) rom[k] = '0;
    repeat (2) @(negedge clock);
    chk_idle_zero("reset");
    resetn = 1'b1;
    repeat (3) @(negedge clock);
    chk("idle_ocup", 32'(ifa.ocupado), 0);

    rom[0] = 4'd5; rom[1] = 4'd3;
    rom[2] = 4'd9; rom[3] = 4'd0;
    start_session();
    play_round(0, 1'b1, 0, 4'd5, 1'b0, 1'b0);
    play_round(1, 1'b1, 2, 4'd4, 1'b0, 1'b0);
    play_round(2, 1'b1, 5, 4'd6, 1'b0, 1'b0);
    play_round(3, 1'b1, 1, 4'd10, 1'b0, 1'b0);
    chk("t1_soma", 32'(ifa.soma), 26);
    chk("t1_last", 32'(ifa.nota_rodada), 0);
    repeat (2) @(negedge clock);
    chk("t1_fim_hold", 32'(ifa.pronto), 1);

    rom[3] = 4'd7;
    start_session();
    play_round(0, 1'b1, 3, 4'd2, 1'b0, 1'b0);
    play_round(1, 1'b0, 0, 4'd0, 1'b0, 1'b0);
    play_round(2, 1'b1, 4, 4'd9, 1'b1, 1'b0);
    play_round(3, 1'b1, TMO - 1, 4'd7, 1'b0, 1'b0);
    chk("t3_nota", 32'(ifa.nota_rodada), 10);

    for (int k = 0; k < N; k++) rom[k] = 4'd9;
    start_session();
    for (int r = 0; r < N; r++)
      play_round(r, 1'b1, r, 4'd9, 1'b0, 1'b0);
    chk("sat_b", 32'(ifb.soma), 15);
    chk("sat_a", 32'(ifa.soma), 40);

    rom[0] = 4'd4; rom[1] = 4'd8;
    start_session();
    play_round(0, 1'b1, 1, 4'd6, 1'b0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    repeat (3) @(negedge clock);
    abortar = 1'b1;
    @(negedge clock);
    abortar = 1'b0;
    chk("ab_ocup", 32'(ifa.ocupado), 0);
    chk("ab_pronto", 32'(ifa.pronto), 0);
    chk("ab_en", 32'(ifa.enable_nota), 0);
    chk("ab_soma", 32'(ifa.soma), 32'(m_sum));
    chk("ab_rod", 32'(ifa.rodada), 1);
    chk("ab_nota", 32'(ifa.nota_rodada), 32'(m_last));
    repeat (2) @(negedge clock);
    chk("ab_idle", 32'(ifa.ocupado), 0);
    random_session();

    for (int n = 0; n < 6; n++) random_session();

    abortar = 1'b1;
    @(negedge clock);
    abortar = 1'b0;
    chk("ab_fim_pronto", 32'(ifa.pronto), 0);
    chk("ab_fim_ocup", 32'(ifa.ocupado), 0);

    rom[0] = 4'd6;
    start_session();
    play_round(0, 1'b1, 2, 4'd6, 1'b0, 1'b1);
    @(negedge clock);
    chk_idle_zero("post_rst");
    random_session();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end
endmodule
